// File: rtl/bike_pkg.sv
// Shared types and default sizing for the bike sensor front-end, distance and speed stages.
package bike_pkg;

   typedef enum logic [1:0] {
      REED_OPEN    = 2'd0,
      REED_CLOSING = 2'd1,
      REED_CLOSED  = 2'd2,
      REED_OPENING = 2'd3
   } reed_state_t;

   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int TIMEOUT_CYCLES_DEF  = 50000;
   localparam int PERIOD_W_DEF        = 16;

endpackage : bike_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous level inputs (reed contact, buttons).
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/reed_conditioner.sv
// Reed switch front-end: synchronise, debounce, emit one pulse per closure,
// measure the cycle gap between accepted pulses and flag a stationary wheel.
//
// state        | meaning
// -------------+---------------------------------------------------------
// REED_OPEN    | debounced level low, waiting for a closed sample
// REED_CLOSING | counting consecutive closed samples toward acceptance
// REED_CLOSED  | debounced level high, waiting for an open sample
// REED_OPENING | counting consecutive open samples toward release
module reed_conditioner
   import bike_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int PERIOD_W        = PERIOD_W_DEF,
   parameter int TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                reed_raw_i,
   input  logic                enable_i,
   output logic                reed_pulse_o,
   output logic [PERIOD_W-1:0] period_o,
   output logic                period_valid_o,
   output logic                stopped_o
);

   localparam logic [7:0]          DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [PERIOD_W-1:0] G_MAX   = PERIOD_W'(TIMEOUT_CYCLES);
   localparam logic [PERIOD_W-1:0] G_ONE   = PERIOD_W'(1);

   logic                reed_s;
   reed_state_t         state_q, state_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                rise;
   logic                accept;

   logic [PERIOD_W-1:0] gap_q, gap_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic                valid_q, valid_d;
   logic                pulse_q, pulse_d;
   logic                stopped_q, stopped_d;

   sync_2ff #(.WIDTH(1)) u_sync (
      .clk_i (clock_i),
      .rst_i (reset_i),
      .d_i   (reed_raw_i),
      .q_o   (reed_s)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rise    = 1'b0;
      case (state_q)
         REED_OPEN: begin
            if (reed_s) begin
               state_d = REED_CLOSING;
               cnt_d   = 8'd1;
            end
         end
         REED_CLOSING: begin
            if (!reed_s) begin
               state_d = REED_OPEN;
               cnt_d   = 8'd0;
            end else if (cnt_q == DB_LAST) begin
               state_d = REED_CLOSED;
               cnt_d   = 8'd0;
               rise    = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         REED_CLOSED: begin
            if (!reed_s) begin
               state_d = REED_OPENING;
               cnt_d   = 8'd1;
            end
         end
         REED_OPENING: begin
            // A re-closure during release returns to CLOSED silently; no new revolution.
            if (reed_s) begin
               state_d = REED_CLOSED;
               cnt_d   = 8'd0;
            end else if (cnt_q == DB_LAST) begin
               state_d = REED_OPEN;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = REED_OPEN;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign accept = rise & enable_i;

   always_comb begin
      gap_d     = gap_q;
      period_d  = period_q;
      valid_d   = 1'b0;
      pulse_d   = accept;
      stopped_d = stopped_q;
      if (accept) begin
         // The first pulse after a stop only arms the measurement.
         gap_d     = '0;
         stopped_d = 1'b0;
         if (!stopped_q) begin
            period_d = gap_q + G_ONE;
            valid_d  = 1'b1;
         end
      end else begin
         if (gap_q < G_MAX) begin
            gap_d = gap_q + G_ONE;
         end
         if (gap_d == G_MAX) begin
            stopped_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q   <= REED_OPEN;
         cnt_q     <= 8'd0;
         gap_q     <= '0;
         period_q  <= '0;
         valid_q   <= 1'b0;
         pulse_q   <= 1'b0;
         stopped_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         gap_q     <= gap_d;
         period_q  <= period_d;
         valid_q   <= valid_d;
         pulse_q   <= pulse_d;
         stopped_q <= stopped_d;
      end
   end

   assign reed_pulse_o   = pulse_q;
   assign period_o       = period_q;
   assign period_valid_o = valid_q;
   assign stopped_o      = stopped_q;

endmodule : reed_conditioner

// File: tb/tb_reed_conditioner.sv
// Directed bench for reed_conditioner: latency, bounce rejection, period, enable gating,
// timeout and mid-debounce reset.
module tb_reed_conditioner;

   logic        clk;
   logic        reset;
   logic        raw, en;
   logic        pulse, valid, stopped;
   logic [15:0] period;
   logic        raw_t, en_t;
   logic        pulse_t, valid_t, stopped_t;
   logic [15:0] period_t;

   int n_checks = 0;
   int n_pass   = 0;
   int pulse_cnt = 0;
   int valid_cnt = 0;
   int valid_t_cnt = 0;
   logic [15:0] last_period = '0;
   logic        valid_coinc = 1'b0;

   reed_conditioner dut (
      .clock_i        (clk),
      .reset_i        (reset),
      .reed_raw_i     (raw),
      .enable_i       (en),
      .reed_pulse_o   (pulse),
      .period_o       (period),
      .period_valid_o (valid),
      .stopped_o      (stopped)
   );

   reed_conditioner #(.TIMEOUT_CYCLES(200)) dut_t (
      .clock_i        (clk),
      .reset_i        (reset),
      .reed_raw_i     (raw_t),
      .enable_i       (en_t),
      .reed_pulse_o   (pulse_t),
      .period_o       (period_t),
      .period_valid_o (valid_t),
      .stopped_o      (stopped_t)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (pulse) pulse_cnt++;
      if (valid) begin
         valid_cnt++;
         last_period = period;
         valid_coinc = pulse;
      end
      if (valid_t) valid_t_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic run_closure(input int spacing, input logic enable);
      en  = enable;
      raw = 1'b1;
      step(40);
      raw = 1'b0;
      en  = 1'b1;
      step(spacing - 40);
   endtask

   int p0, v0;

   initial begin
      reset = 1'b1; raw = 1'b0; en = 1'b1; raw_t = 1'b0; en_t = 1'b1;
      step(3);
      chk("rst_pulse",   pulse,   0);
      chk("rst_period",  period,  0);
      chk("rst_valid",   valid,   0);
      chk("rst_stopped", stopped, 1);
      reset = 1'b0;
      step(3);

      // clean closure: pulse only in the cycle after relative edge 17
      raw = 1'b1;
      step(17);
      chk("lat_early_pulse",   pulse,   0);
      chk("lat_early_stopped", stopped, 1);
      step(1);
      chk("lat_pulse",   pulse,   1);
      chk("lat_stopped", stopped, 0);
      chk("lat_valid",   valid,   0);
      step(1);
      chk("lat_one_cycle", pulse,     0);
      chk("lat_count",     pulse_cnt, 1);
      raw = 1'b0;
      step(40);

      // bounce 5 high / 3 low x4, then stay high
      p0 = pulse_cnt;
      for (int i = 0; i < 4; i++) begin
         raw = 1'b1; step(5);
         raw = 1'b0; step(3);
      end
      chk("bounce_quiet", pulse_cnt, p0);
      raw = 1'b1;
      step(17);
      chk("bounce_early", pulse_cnt, p0);
      step(1);
      chk("bounce_pulse", pulse, 1);
      step(5);
      chk("bounce_single", pulse_cnt, p0 + 1);
      raw = 1'b0;
      step(40);

      // period measurement
      run_closure(1000, 1'b1);
      v0 = valid_cnt;
      run_closure(750, 1'b1);
      chk("period_1000",       last_period, 1000);
      chk("period_1000_coinc", valid_coinc, 1);
      chk("period_1000_once",  valid_cnt,   v0 + 1);
      run_closure(400, 1'b1);
      chk("period_750", last_period, 750);
      chk("period_out", period,      750);

      // enable gating
      p0 = pulse_cnt;
      v0 = valid_cnt;
      run_closure(400, 1'b0);
      chk("dis_no_pulse", pulse_cnt, p0);
      chk("dis_no_valid", valid_cnt, v0);
      run_closure(400, 1'b1);
      chk("en_period_800", last_period, 800);
      chk("en_pulse",      pulse_cnt,   p0 + 1);

      // timeout instance: every pulse only arms
      for (int k = 0; k < 3; k++) begin
         raw_t = 1'b1;
         step(17);
         chk("tmo_pre_stopped", stopped_t, 1);
         step(1);
         chk("tmo_pulse",   pulse_t,   1);
         chk("tmo_armed",   stopped_t, 0);
         raw_t = 1'b0;
         step(199);
         chk("tmo_199", stopped_t, 0);
         step(1);
         chk("tmo_200", stopped_t, 1);
         step(32);
      end
      chk("tmo_no_valid", valid_t_cnt, 0);
      chk("tmo_period",   period_t,    0);

      // reset in the middle of CLOSING with the contact held closed
      p0 = pulse_cnt;
      raw = 1'b1;
      step(12);
      reset = 1'b1;
      step(1);
      chk("mid_no_pulse", pulse_cnt, p0);
      step(2);
      chk("mid_rst_stopped", stopped, 1);
      chk("mid_rst_period",  period,  0);
      chk("mid_rst_valid",   valid,   0);
      reset = 1'b0;
      step(17);
      chk("rel_early", pulse_cnt, p0);
      step(1);
      chk("rel_pulse",   pulse,   1);
      chk("rel_valid",   valid,   0);
      chk("rel_stopped", stopped, 0);
      chk("rel_period",  period,  0);
      step(3);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_reed_conditioner
